// File: rtl/or_event_monitor.sv
// ----------------------------------------------------------------------------
// or_event_monitor
//
// Watches the asynchronous output of an upstream 3-input OR stage and counts
// its rising edges. The input is brought into the clock domain through a
// flop chain, rising edges are detected against the previous synchronised
// value, and a small FSM imposes a hold-off window after every counted event
// followed by a wait for the input to return low. This gives one count per
// OR-stage assertion even if the input is noisy or stays high for a long time.
//
// A saturating event counter with a sticky overflow flag is exposed live.
// A single-entry snapshot register with a req/ack handshake allows a consumer
// to capture the count at a chosen instant and read it at leisure.
//
// Parameters
//   SYNC_STAGES  synchroniser depth on y_in (2..4)
//   HOLDOFF      cycles spent ignoring the input after an event (1..255)
//   CNT_W        width of count and snap_count
//
// Ports
//   clk          clock, all state changes on the rising edge
//   rst_n        asynchronous active-low reset
//   y_in         asynchronous OR-stage output being monitored
//   enable       1 = armed, 0 = idle (count/snapshot retained)
//   clr          synchronous clear of count and overflow
//   snap_req     one-cycle request to capture count
//   snap_ack     consumer acknowledge, frees the snapshot register
//   count        live event count (saturating)
//   overflow     sticky flag, set by an event arriving at saturation
//   event_pulse  one-cycle strobe per counted event
//   snap_valid   snapshot register holds a value
//   snap_count   captured count, stable while snap_valid is high
//   state        FSM state: 0 idle, 1 armed, 2 hold, 3 wait-low
// ----------------------------------------------------------------------------
module or_event_monitor #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned HOLDOFF     = 4,
    parameter int unsigned CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             y_in,
    input  logic             enable,
    input  logic             clr,
    input  logic             snap_req,
    input  logic             snap_ack,
    output logic [CNT_W-1:0] count,
    output logic             overflow,
    output logic             event_pulse,
    output logic             snap_valid,
    output logic [CNT_W-1:0] snap_count,
    output logic [1:0]       state
);

    // ------------------------------------------------------------------------
    // Local constants and types
    // ------------------------------------------------------------------------
    // Hold-off counter is loaded with HOLDOFF-1 so the FSM spends exactly
    // HOLDOFF cycles in StHold (it leaves on the cycle the counter reads 0).
    localparam logic [7:0]       HOLD_LOAD = 8'(HOLDOFF - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StArmed   = 2'd1,
        StHold    = 2'd2,
        StWaitLow = 2'd3
    } state_e;

    // ------------------------------------------------------------------------
    // Signals
    // ------------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   y_s;
    logic                   y_prev_q;
    logic                   rise;

    state_e                 state_q, state_d;
    logic [7:0]             hold_cnt_q, hold_cnt_d;
    logic                   event_hit;

    logic [CNT_W-1:0]       count_q, count_d;
    logic                   overflow_q, overflow_d;
    logic                   event_pulse_q, event_pulse_d;

    logic                   snap_valid_q, snap_valid_d;
    logic [CNT_W-1:0]       snap_count_q, snap_count_d;

    // ------------------------------------------------------------------------
    // Input synchroniser and rise detector
    // ------------------------------------------------------------------------
    // y_in enters at bit 0 and leaves at the top bit.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], y_in};
    end

    assign y_s  = sync_q[SYNC_STAGES-1];
    assign rise = y_s & ~y_prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q   <= '0;
            y_prev_q <= 1'b0;
        end else begin
            sync_q   <= sync_d;
            y_prev_q <= y_s;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // An event is only ever recognised while armed and still enabled; rises
    // in any other state (notably during hold-off) are discarded.
    assign event_hit = enable && (state_q == StArmed) && rise;

    // ------------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        if (!enable) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    state_d = StArmed;
                end
                StArmed: begin
                    if (rise) begin
                        state_d = StHold;
                    end
                end
                StHold: begin
                    if (hold_cnt_q == 8'd0) begin
                        state_d = StWaitLow;
                    end
                end
                StWaitLow: begin
                    // Re-arm only once the input has been seen low, so a
                    // steady-high input is counted once.
                    if (!y_s) begin
                        state_d = StArmed;
                    end
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Hold-off counter
    // ------------------------------------------------------------------------
    always_comb begin
        hold_cnt_d = hold_cnt_q;
        if (!enable) begin
            hold_cnt_d = 8'd0;
        end else if (event_hit) begin
            hold_cnt_d = HOLD_LOAD;
        end else if ((state_q == StHold) && (hold_cnt_q != 8'd0)) begin
            hold_cnt_d = hold_cnt_q - 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt_q <= 8'd0;
        end else begin
            hold_cnt_q <= hold_cnt_d;
        end
    end

    // ------------------------------------------------------------------------
    // Event counter, overflow flag and event strobe
    // ------------------------------------------------------------------------
    always_comb begin
        count_d       = count_q;
        overflow_d    = overflow_q;
        event_pulse_d = event_hit;
        if (clr) begin
            // Clear wins over an increment landing on the same edge.
            count_d    = '0;
            overflow_d = 1'b0;
        end else if (event_hit) begin
            if (count_q == CNT_MAX) begin
                overflow_d = 1'b1;
            end else begin
                count_d = count_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q       <= '0;
            overflow_q    <= 1'b0;
            event_pulse_q <= 1'b0;
        end else begin
            count_q       <= count_d;
            overflow_q    <= overflow_d;
            event_pulse_q <= event_pulse_d;
        end
    end

    // ------------------------------------------------------------------------
    // Snapshot register with req/ack handshake
    // ------------------------------------------------------------------------
    // While valid, only an ack is acted on; a request arriving alongside the
    // ack is dropped rather than recapturing.
    always_comb begin
        snap_valid_d = snap_valid_q;
        snap_count_d = snap_count_q;
        if (snap_valid_q) begin
            if (snap_ack) begin
                snap_valid_d = 1'b0;
            end
        end else if (snap_req) begin
            snap_valid_d = 1'b1;
            snap_count_d = count_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap_valid_q <= 1'b0;
            snap_count_q <= '0;
        end else begin
            snap_valid_q <= snap_valid_d;
            snap_count_q <= snap_count_d;
        end
    end

    // ------------------------------------------------------------------------
    // FSM / block outputs
    // ------------------------------------------------------------------------
    always_comb begin
        state       = state_q;
        count       = count_q;
        overflow    = overflow_q;
        event_pulse = event_pulse_q;
        snap_valid  = snap_valid_q;
        snap_count  = snap_count_q;
    end

endmodule

// File: tb/tb_or_event_monitor.sv
// ----------------------------------------------------------------------------
// Bench for or_event_monitor. Stimulus pushes expected event strobes (cycle,
// count, overflow) and expected snapshot captures into queues; a monitor pops
// and compares whenever the DUT strobes event_pulse or raises snap_valid.
// A second instance with CNT_W=2 covers saturation.
// ----------------------------------------------------------------------------
module tb_or_event_monitor;

    typedef struct {
        int cyc;
        int cnt;
        int ovf;
    } ev_t;

    logic       clk;
    logic       rst_n;
    logic       y_in;
    logic       enable;
    logic       clr;
    logic       snap_req;
    logic       snap_ack;

    logic [7:0] count;
    logic       overflow;
    logic       event_pulse;
    logic       snap_valid;
    logic [7:0] snap_count;
    logic [1:0] state;

    logic [1:0] count2;
    logic       overflow2;
    logic       event_pulse2;
    logic       snap_valid2;
    logic [1:0] snap_count2;
    logic [1:0] state2;

    int  n_vec  = 0;
    int  n_err  = 0;
    int  cyc    = 0;
    int  n_puls = 0;
    ev_t evq[$];
    int  snapq[$];
    ev_t mon_e;
    int  mon_s;
    logic sv_prev = 1'b0;

    int st_tbl [14] = '{1, 1, 2, 2, 2, 2, 3, 3, 3, 3, 3, 3, 1, 1};

    or_event_monitor #(
        .SYNC_STAGES (2),
        .HOLDOFF     (4),
        .CNT_W       (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .y_in        (y_in),
        .enable      (enable),
        .clr         (clr),
        .snap_req    (snap_req),
        .snap_ack    (snap_ack),
        .count       (count),
        .overflow    (overflow),
        .event_pulse (event_pulse),
        .snap_valid  (snap_valid),
        .snap_count  (snap_count),
        .state       (state)
    );

    or_event_monitor #(
        .SYNC_STAGES (2),
        .HOLDOFF     (4),
        .CNT_W       (2)
    ) dut2 (
        .clk         (clk),
        .rst_n       (rst_n),
        .y_in        (y_in),
        .enable      (enable),
        .clr         (clr),
        .snap_req    (snap_req),
        .snap_ack    (snap_ack),
        .count       (count2),
        .overflow    (overflow2),
        .event_pulse (event_pulse2),
        .snap_valid  (snap_valid2),
        .snap_count  (snap_count2),
        .state       (state2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_ev(input int c, input int cnt, input int ovf);
        ev_t e;
        e.cyc = c;
        e.cnt = cnt;
        e.ovf = ovf;
        evq.push_back(e);
    endtask

    // One isolated event starting and ending in ARMED; optional clr landing
    // on the same edge as the increment.
    task automatic fire(input int exp_cnt, input int exp_ovf, input bit clr_on_edge);
        push_ev(cyc + 3, exp_cnt, exp_ovf);
        y_in = 1'b1;
        tick(2);
        y_in = 1'b0;
        clr  = clr_on_edge;
        tick(1);
        clr  = 1'b0;
        tick(7);
    endtask

    // Monitor: compares each DUT presentation against the queued expectation.
    always @(negedge clk) begin
        if (rst_n) begin
            if (event_pulse) begin
                n_puls++;
                if (evq.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_pulse: got pulse at cycle %0d required none", cyc);
                end else begin
                    mon_e = evq.pop_front();
                    chk("pulse_cycle", cyc, mon_e.cyc);
                    chk("pulse_count", int'(count), mon_e.cnt);
                    chk("pulse_ovf", int'(overflow), mon_e.ovf);
                end
            end
            if (snap_valid && !sv_prev) begin
                if (snapq.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_snap: got capture at cycle %0d required none", cyc);
                end else begin
                    mon_s = snapq.pop_front();
                    chk("snap_count", int'(snap_count), mon_s);
                end
            end
        end
        sv_prev = snap_valid;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout required $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int m;
        int p;
        int n;
        int r;
        int s;
        int pb;
        logic [2:0] abc;

        rst_n    = 1'b1;
        y_in     = 1'b0;
        enable   = 1'b0;
        clr      = 1'b0;
        snap_req = 1'b0;
        snap_ack = 1'b0;
        #1 rst_n = 1'b0;
        tick(3);
        chk("rst_count", int'(count), 0);
        chk("rst_ovf", int'(overflow), 0);
        chk("rst_pulse", int'(event_pulse), 0);
        chk("rst_snap_valid", int'(snap_valid), 0);
        chk("rst_snap_count", int'(snap_count), 0);
        chk("rst_state", int'(state), 0);

        rst_n = 1'b1;
        tick(2);
        chk("idle_hold", int'(state), 0);
        enable = 1'b1;
        tick(1);
        chk("idle_to_armed", int'(state), 1);

        // Single long pulse: state walk ARMED-HOLD x4-WAIT_LOW-ARMED.
        m = cyc;
        push_ev(m + 3, 1, 0);
        y_in = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            tick(1);
            chk($sformatf("t1_state_k%0d", k), int'(state), st_tbl[k-1]);
            if (k == 10) y_in = 1'b0;
        end
        chk("t1_count", int'(count), 1);

        // Toggling input: only rises seen while armed count.
        p = cyc;
        push_ev(p + 3, 2, 0);
        push_ev(p + 9, 3, 0);
        for (int i = 0; i < 8; i++) begin
            y_in = (i % 2 == 0);
            tick(1);
        end
        y_in = 1'b0;
        tick(8);
        chk("t2_count", int'(count), 3);
        chk("t2_state", int'(state), 1);

        fire(4, 0, 1'b0);
        fire(5, 0, 1'b0);

        // Snapshot request coincident with the event edge captures pre-increment.
        n = cyc;
        push_ev(n + 3, 6, 0);
        snapq.push_back(5);
        y_in = 1'b1;
        tick(2);
        y_in     = 1'b0;
        snap_req = 1'b1;
        tick(1);
        snap_req = 1'b0;
        chk("t3_snap_valid", int'(snap_valid), 1);
        chk("t3_count", int'(count), 6);
        tick(1);
        snap_req = 1'b1;
        tick(1);
        snap_req = 1'b0;
        chk("t3_snap_stable", int'(snap_count), 5);
        chk("t3_snap_still_valid", int'(snap_valid), 1);
        tick(5);
        snap_ack = 1'b1;
        tick(1);
        snap_ack = 1'b0;
        chk("t3_ack_clears", int'(snap_valid), 0);
        snapq.push_back(6);
        snap_req = 1'b1;
        tick(1);
        snap_req = 1'b0;
        chk("t3_recapture", int'(snap_valid), 1);
        snap_req = 1'b1;
        snap_ack = 1'b1;
        tick(1);
        snap_req = 1'b0;
        snap_ack = 1'b0;
        chk("t3_reqack_clears", int'(snap_valid), 0);
        tick(1);
        chk("t3_no_recapture", int'(snap_valid), 0);

        // Asynchronous reset in the middle of HOLD with a snapshot pending.
        n = cyc;
        snapq.push_back(6);
        snap_req = 1'b1;
        push_ev(n + 3, 7, 0);
        y_in = 1'b1;
        tick(1);
        snap_req = 1'b0;
        tick(3);
        chk("t4_state_hold", int'(state), 2);
        chk("t4_count", int'(count), 7);
        chk("t4_snap_valid", int'(snap_valid), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t4_async_count", int'(count), 0);
        chk("t4_async_ovf", int'(overflow), 0);
        chk("t4_async_pulse", int'(event_pulse), 0);
        chk("t4_async_snap_valid", int'(snap_valid), 0);
        chk("t4_async_snap_count", int'(snap_count), 0);
        chk("t4_async_state", int'(state), 0);
        tick(3);
        rst_n = 1'b1;
        r = cyc;
        push_ev(r + 3, 1, 0);
        tick(1);
        chk("t4_rearm", int'(state), 1);
        tick(9);
        chk("t4_wait_low", int'(state), 3);
        chk("t4_count_after", int'(count), 1);

        // y_in driven from OR of A,B,C over all combinations: one event.
        tick(0);
        s  = cyc;
        pb = n_puls;
        push_ev(s + 7, 2, 0);
        for (int c = 0; c < 8; c++) begin
            abc  = 3'(c);
            y_in = abc[0] | abc[1] | abc[2];
            tick(4);
        end
        chk("t5_count", int'(count), 2);
        chk("t5_one_pulse", n_puls - pb, 1);

        // Clear racing an increment, then saturation on the 2-bit instance.
        y_in = 1'b0;
        tick(4);
        chk("t6_armed", int'(state), 1);
        fire(0, 0, 1'b1);
        chk("t6_clr_win2", int'(count2), 0);
        chk("t6_clr_win2_ovf", int'(overflow2), 0);
        for (int k = 1; k <= 5; k++) begin
            fire(k, 0, 1'b0);
            chk($sformatf("t6_cnt2_ev%0d", k), int'(count2), (k > 3) ? 3 : k);
            chk($sformatf("t6_ovf2_ev%0d", k), int'(overflow2), (k >= 4) ? 1 : 0);
        end
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        chk("t6_clr_count", int'(count), 0);
        chk("t6_clr_ovf", int'(overflow), 0);
        chk("t6_clr_count2", int'(count2), 0);
        chk("t6_clr_ovf2", int'(overflow2), 0);
        chk("t6_state2", int'(state2), 1);
        chk("t6_pulse2", int'(event_pulse2), 0);
        chk("t6_snap_valid2", int'(snap_valid2), 0);
        chk("t6_snap_count2", int'(snap_count2), 0);

        tick(2);
        chk("evq_drained", evq.size(), 0);
        chk("snapq_drained", snapq.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
